// File: rtl/a_defines.sv
// Shared datapath types used across the out-of-order core.
package a_defines;
    typedef logic [31:0] word_t;
    typedef logic [5:0]  rob_id_t;
    typedef struct packed {
        logic [4:0] opcode;
        logic [2:0] fu_sel;
    } decode_info_t;
endpackage

// File: rtl/iq_issue_select_pkg.sv
// Issue-select defaults and the oldest-first ordering primitive.
package iq_issue_select_pkg;
    localparam int IQ_DEPTH_DEFAULT  = 8;
    localparam int REG_COUNT_DEFAULT = 2;

    // Entries never allocated since reset/flush have no matrix ordering; lower index wins.
    function automatic logic is_older(logic age_ji, logic age_ij, logic j_lower);
        return age_ji | (~age_ij & j_lower);
    endfunction
endpackage

// File: rtl/iq_issue_select_if.sv
// Issue-register and wakeup bundle between the select stage and the FU.
interface iq_issue_select_if #(parameter int REG_COUNT = 2) ();
    import a_defines::*;

    logic                       iss_valid_o;
    logic                       fu_ready_i;
    word_t [REG_COUNT-1:0]      iss_data_o;
    decode_info_t               iss_di_o;
    rob_id_t                    iss_dst_id_o;
    logic                       wkup_valid_o;
    rob_id_t                    wkup_reg_id_o;

    modport master (
        output iss_valid_o, iss_data_o, iss_di_o, iss_dst_id_o, wkup_valid_o, wkup_reg_id_o,
        input  fu_ready_i
    );
    modport slave (
        input  iss_valid_o, iss_data_o, iss_di_o, iss_dst_id_o, wkup_valid_o, wkup_reg_id_o,
        output fu_ready_i
    );
endinterface

// File: rtl/iq_age_matrix.sv
// Age matrix for the issue queue: tracks allocation order and grants the oldest requester.
module iq_age_matrix
    import iq_issue_select_pkg::*;
#(
    parameter int IQ_DEPTH = IQ_DEPTH_DEFAULT
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        flush,
    input  logic                        alloc_valid_i,
    input  logic [$clog2(IQ_DEPTH)-1:0] alloc_idx_i,
    input  logic [IQ_DEPTH-1:0]         req_i,
    output logic [IQ_DEPTH-1:0]         grant_o
);
    logic [IQ_DEPTH-1:0][IQ_DEPTH-1:0] age_q;
    logic [IQ_DEPTH-1:0][IQ_DEPTH-1:0] age_d;

    always_comb begin
        age_d = age_q;
        if (flush) begin
            age_d = '0;
        end else if (alloc_valid_i) begin
            // Column first, then row, so the diagonal ends up cleared.
            for (int j = 0; j < IQ_DEPTH; j++) begin
                age_d[j][alloc_idx_i] = 1'b1;
                age_d[alloc_idx_i][j] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) age_q <= '0;
        else        age_q <= age_d;
    end

    always_comb begin
        logic blocked;
        grant_o = '0;
        for (int i = 0; i < IQ_DEPTH; i++) begin
            blocked = 1'b0;
            for (int j = 0; j < IQ_DEPTH; j++) begin
                if (j != i && req_i[j] && is_older(age_q[j][i], age_q[i][j], j < i))
                    blocked = 1'b1;
            end
            grant_o[i] = req_i[i] & ~blocked;
        end
    end
endmodule

// File: rtl/iq_issue_select.sv
// Issue select: oldest-ready grant, single-entry issue register and back-to-back wakeup.
module iq_issue_select
    import a_defines::*;
    import iq_issue_select_pkg::*;
#(
    parameter int IQ_DEPTH  = IQ_DEPTH_DEFAULT,
    parameter int REG_COUNT = REG_COUNT_DEFAULT
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  flush,
    input  logic                                  alloc_valid_i,
    input  logic [$clog2(IQ_DEPTH)-1:0]           alloc_idx_i,
    input  logic [IQ_DEPTH-1:0]                   entry_valid_i,
    input  logic [IQ_DEPTH-1:0]                   entry_ready_i,
    input  word_t [IQ_DEPTH-1:0][REG_COUNT-1:0]   entry_data_i,
    input  decode_info_t [IQ_DEPTH-1:0]           entry_di_i,
    input  rob_id_t [IQ_DEPTH-1:0]                entry_dst_id_i,
    output logic [IQ_DEPTH-1:0]                   select_o,
    iq_issue_select_if.master                     iss_if
);
    logic [IQ_DEPTH-1:0]   req;
    logic [IQ_DEPTH-1:0]   grant;
    logic [IQ_DEPTH-1:0]   sel;
    logic                  accept;
    word_t [REG_COUNT-1:0] sel_data;
    decode_info_t          sel_di;
    rob_id_t               sel_dst_id;

    logic                  iss_valid_q,  iss_valid_d;
    word_t [REG_COUNT-1:0] iss_data_q,   iss_data_d;
    decode_info_t          iss_di_q,     iss_di_d;
    rob_id_t               iss_dst_id_q, iss_dst_id_d;

    assign req = entry_valid_i & entry_ready_i;

    iq_age_matrix #(.IQ_DEPTH(IQ_DEPTH)) u_age (
        .clk           (clk),
        .rst_n         (rst_n),
        .flush         (flush),
        .alloc_valid_i (alloc_valid_i),
        .alloc_idx_i   (alloc_idx_i),
        .req_i         (req),
        .grant_o       (grant)
    );

    always_comb begin
        accept     = ~iss_valid_q | iss_if.fu_ready_i;
        sel        = (rst_n && !flush && accept) ? grant : '0;
        sel_data   = '0;
        sel_di     = '0;
        sel_dst_id = '0;
        for (int i = 0; i < IQ_DEPTH; i++) begin
            if (sel[i]) begin
                sel_data   = entry_data_i[i];
                sel_di     = entry_di_i[i];
                sel_dst_id = entry_dst_id_i[i];
            end
        end
    end

    // Payload only moves on a new select; consumers qualify it with iss_valid.
    always_comb begin
        iss_valid_d  = iss_valid_q;
        iss_data_d   = iss_data_q;
        iss_di_d     = iss_di_q;
        iss_dst_id_d = iss_dst_id_q;
        if (|sel) begin
            iss_valid_d  = 1'b1;
            iss_data_d   = sel_data;
            iss_di_d     = sel_di;
            iss_dst_id_d = sel_dst_id;
        end else if (iss_if.fu_ready_i) begin
            iss_valid_d  = 1'b0;
        end
        if (flush) iss_valid_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            iss_valid_q  <= 1'b0;
            iss_data_q   <= '0;
            iss_di_q     <= '0;
            iss_dst_id_q <= '0;
        end else begin
            iss_valid_q  <= iss_valid_d;
            iss_data_q   <= iss_data_d;
            iss_di_q     <= iss_di_d;
            iss_dst_id_q <= iss_dst_id_d;
        end
    end

    assign select_o             = sel;
    assign iss_if.wkup_valid_o  = |sel;
    assign iss_if.wkup_reg_id_o = sel_dst_id;
    assign iss_if.iss_valid_o   = iss_valid_q;
    assign iss_if.iss_data_o    = iss_data_q;
    assign iss_if.iss_di_o      = iss_di_q;
    assign iss_if.iss_dst_id_o  = iss_dst_id_q;
endmodule

// File: tb/tb_iq_issue_select.sv
// Self-checking bench for iq_issue_select: allocation-order model plus expected-payload queue.
module tb_iq_issue_select;
    import a_defines::*;

    localparam int D = 8;
    localparam int R = 2;

    typedef struct {
        rob_id_t          dst;
        word_t [R-1:0]    data;
        decode_info_t     di;
    } pay_t;

    logic clk = 1'b0;
    logic rst_n, flush, alloc_valid;
    logic [2:0] alloc_idx;
    logic [D-1:0] ev, er, select;
    word_t [D-1:0][R-1:0] edata;
    decode_info_t [D-1:0] edi;
    rob_id_t [D-1:0] edst;

    iq_issue_select_if #(.REG_COUNT(R)) iss_if ();

    iq_issue_select #(.IQ_DEPTH(D), .REG_COUNT(R)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .flush          (flush),
        .alloc_valid_i  (alloc_valid),
        .alloc_idx_i    (alloc_idx),
        .entry_valid_i  (ev),
        .entry_ready_i  (er),
        .entry_data_i   (edata),
        .entry_di_i     (edi),
        .entry_dst_id_i (edst),
        .select_o       (select),
        .iss_if         (iss_if)
    );

    always #5 clk = ~clk;

    int pass_cnt = 0;
    int total_cnt = 0;

    bit m_iss_valid;
    int m_stamp[D];
    int stamp_ctr;
    pay_t pq[$];
    pay_t exp_pay;
    logic [D-1:0] exp_sel;
    rob_id_t exp_wid;

    // Reference model: oldest = smallest allocation stamp, never-allocated (-1) tie on index.
    task automatic predict();
        int best;
        bit acc;
        pay_t p;
        best = -1;
        exp_sel = '0;
        exp_wid = '0;
        acc = !m_iss_valid || iss_if.fu_ready_i;
        if (rst_n && !flush && acc)
            for (int i = 0; i < D; i++)
                if (ev[i] && er[i] && (best < 0 || m_stamp[i] < m_stamp[best])) best = i;
        if (!rst_n) begin
            m_iss_valid = 0;
            foreach (m_stamp[i]) m_stamp[i] = -1;
            pq.delete();
            p.dst = '0; p.data = '0; p.di = '0;
            pq.push_back(p);
        end else begin
            if (best >= 0) begin
                exp_sel[best] = 1'b1;
                exp_wid = edst[best];
                p.dst = edst[best]; p.data = edata[best]; p.di = edi[best];
                pq.push_back(p);
                m_iss_valid = 1;
            end else if (iss_if.fu_ready_i) begin
                m_iss_valid = 0;
            end
            if (flush) begin
                m_iss_valid = 0;
                foreach (m_stamp[i]) m_stamp[i] = -1;
            end else if (alloc_valid) begin
                m_stamp[alloc_idx] = stamp_ctr;
                stamp_ctr++;
            end
        end
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
        if (pq.size() > 0) exp_pay = pq.pop_front();
        alloc_valid = 1'b0;
        flush = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        ev = '1; er = '1;
        iss_if.fu_ready_i = 1'b1;
        #2;
        predict();
        total_cnt++; if (select !== 8'h00) $display("FAIL reset_select got %h exp 00", select); else pass_cnt++;
        total_cnt++; if (iss_if.wkup_valid_o !== 1'b0) $display("FAIL reset_wkup got %b exp 0", iss_if.wkup_valid_o); else pass_cnt++;
        advance();
        total_cnt++; if (iss_if.iss_valid_o !== 1'b0) $display("FAIL reset_iss_valid got %b exp 0", iss_if.iss_valid_o); else pass_cnt++;
        total_cnt++; if ({iss_if.iss_dst_id_o, iss_if.iss_data_o, iss_if.iss_di_o} !== '0)
            $display("FAIL reset_payload got %h exp 0", {iss_if.iss_dst_id_o, iss_if.iss_data_o, iss_if.iss_di_o}); else pass_cnt++;
        total_cnt++; if (dut.u_age.age_q !== '0) $display("FAIL reset_age got %h exp 0", dut.u_age.age_q); else pass_cnt++;
        rst_n = 1'b1;
        ev = '0; er = '0;
    endtask

    task automatic test_age_order();
        alloc_valid = 1'b1; alloc_idx = 3'd3; ev[3] = 1'b1;
        #2; predict(); advance();
        alloc_valid = 1'b1; alloc_idx = 3'd1; ev[1] = 1'b1;
        #2; predict(); advance();
        er[3] = 1'b1; er[1] = 1'b1;
        #2; predict();
        total_cnt++; if (select !== 8'h08 || select !== exp_sel) $display("FAIL age_first_select got %h exp 08", select); else pass_cnt++;
        advance();
        ev[3] = 1'b0;
        total_cnt++; if (iss_if.iss_dst_id_o !== edst[3] || exp_pay.dst !== edst[3])
            $display("FAIL age_first_dst got %h exp %h", iss_if.iss_dst_id_o, edst[3]); else pass_cnt++;
        #2; predict();
        total_cnt++; if (select !== 8'h02 || select !== exp_sel) $display("FAIL age_second_select got %h exp 02", select); else pass_cnt++;
        advance();
        total_cnt++; if (iss_if.iss_dst_id_o !== exp_pay.dst) $display("FAIL age_second_dst got %h exp %h", iss_if.iss_dst_id_o, exp_pay.dst); else pass_cnt++;
    endtask

    task automatic test_fu_stall();
        ev = 8'h01; er = 8'h01;
        iss_if.fu_ready_i = 1'b0;
        #2; predict();
        total_cnt++; if (select !== 8'h00 || select !== exp_sel) $display("FAIL stall_select got %h exp 00", select); else pass_cnt++;
        total_cnt++; if (iss_if.wkup_valid_o !== 1'b0) $display("FAIL stall_wkup got %b exp 0", iss_if.wkup_valid_o); else pass_cnt++;
        advance();
        total_cnt++; if (iss_if.iss_valid_o !== 1'b1 || iss_if.iss_dst_id_o !== exp_pay.dst || iss_if.iss_data_o !== exp_pay.data)
            $display("FAIL stall_hold got v=%b dst=%h exp v=1 dst=%h", iss_if.iss_valid_o, iss_if.iss_dst_id_o, exp_pay.dst); else pass_cnt++;
        iss_if.fu_ready_i = 1'b1;
        #2; predict(); advance();
        ev = '0; er = '0;
    endtask

    task automatic test_wakeup();
        ev[5] = 1'b1; er[5] = 1'b1; edst[5] = 6'd17;
        #2; predict();
        total_cnt++; if (iss_if.wkup_valid_o !== 1'b1) $display("FAIL wkup_valid got %b exp 1", iss_if.wkup_valid_o); else pass_cnt++;
        total_cnt++; if (iss_if.wkup_reg_id_o !== 6'd17 || exp_wid !== 6'd17) $display("FAIL wkup_id got %0d exp 17", iss_if.wkup_reg_id_o); else pass_cnt++;
        total_cnt++; if (select !== exp_sel) $display("FAIL wkup_select got %h exp %h", select, exp_sel); else pass_cnt++;
        advance();
        ev[5] = 1'b0;
        total_cnt++; if (iss_if.iss_valid_o !== 1'b1 || iss_if.iss_dst_id_o !== 6'd17 || iss_if.iss_data_o !== exp_pay.data || iss_if.iss_di_o !== exp_pay.di)
            $display("FAIL wkup_issue got v=%b dst=%0d exp v=1 dst=17", iss_if.iss_valid_o, iss_if.iss_dst_id_o); else pass_cnt++;
    endtask

    task automatic test_flush();
        ev[2] = 1'b1; er[2] = 1'b1;
        flush = 1'b1;
        #2; predict();
        total_cnt++; if (select !== 8'h00) $display("FAIL flush_select got %h exp 00", select); else pass_cnt++;
        total_cnt++; if (iss_if.wkup_valid_o !== 1'b0) $display("FAIL flush_wkup got %b exp 0", iss_if.wkup_valid_o); else pass_cnt++;
        advance();
        total_cnt++; if (iss_if.iss_valid_o !== 1'b0) $display("FAIL flush_iss_valid got %b exp 0", iss_if.iss_valid_o); else pass_cnt++;
        total_cnt++; if (dut.u_age.age_q !== '0) $display("FAIL flush_age got %h exp 0", dut.u_age.age_q); else pass_cnt++;
        ev = '0; er = '0;
    endtask

    task automatic test_alloc_same();
        alloc_valid = 1'b1; alloc_idx = 3'd4; ev[4] = 1'b1;
        #2; predict(); advance();
        alloc_valid = 1'b1; alloc_idx = 3'd6; ev[6] = 1'b1;
        #2; predict(); advance();
        er[4] = 1'b1; alloc_valid = 1'b1; alloc_idx = 3'd4;
        #2; predict();
        total_cnt++; if (select !== 8'h10 || select !== exp_sel) $display("FAIL same_select got %h exp 10", select); else pass_cnt++;
        advance();
        total_cnt++; if (iss_if.iss_data_o !== exp_pay.data || iss_if.iss_dst_id_o !== 6'd14)
            $display("FAIL same_old_payload got %h exp %h", iss_if.iss_data_o, exp_pay.data); else pass_cnt++;
        total_cnt++; if (dut.u_age.age_q[4] !== 8'h00 || dut.u_age.age_q[6][4] !== 1'b1 || dut.u_age.age_q[0][4] !== 1'b1)
            $display("FAIL same_youngest got row4=%h exp 00", dut.u_age.age_q[4]); else pass_cnt++;
        edata[4][0] = 32'hC0DE_0004; edst[4] = 6'd40;
        er[6] = 1'b1;
        #2; predict();
        total_cnt++; if (select !== 8'h40 || select !== exp_sel) $display("FAIL same_order got %h exp 40", select); else pass_cnt++;
        advance();
        ev[6] = 1'b0;
        #2; predict();
        total_cnt++; if (select !== 8'h10) $display("FAIL same_new_select got %h exp 10", select); else pass_cnt++;
        advance();
        total_cnt++; if (iss_if.iss_dst_id_o !== 6'd40 || iss_if.iss_data_o !== exp_pay.data)
            $display("FAIL same_new_payload got %h exp 40", iss_if.iss_dst_id_o); else pass_cnt++;
        ev = '0; er = '0;
    endtask

    task automatic test_back_to_back();
        ev = 8'h0F; er = 8'h0F;
        iss_if.fu_ready_i = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #2; predict();
            total_cnt++; if (select !== exp_sel || iss_if.wkup_reg_id_o !== exp_wid)
                $display("FAIL b2b_select c%0d got %h/%h exp %h/%h", c, select, iss_if.wkup_reg_id_o, exp_sel, exp_wid); else pass_cnt++;
            advance();
            ev = ev & ~exp_sel;
            total_cnt++; if (iss_if.iss_valid_o !== 1'b1 || iss_if.iss_dst_id_o !== exp_pay.dst)
                $display("FAIL b2b_issue c%0d got %h exp %h", c, iss_if.iss_dst_id_o, exp_pay.dst); else pass_cnt++;
        end
        rst_n = 1'b0;
        #2; predict();
        total_cnt++; if (select !== 8'h00 || iss_if.wkup_valid_o !== 1'b0)
            $display("FAIL b2b_rst_select got %h/%b exp 00/0", select, iss_if.wkup_valid_o); else pass_cnt++;
        advance();
        total_cnt++; if (iss_if.iss_valid_o !== 1'b0 || {iss_if.iss_dst_id_o, iss_if.iss_data_o, iss_if.iss_di_o} !== '0 || select !== 8'h00)
            $display("FAIL b2b_rst_outputs got v=%b dst=%h sel=%h exp all 0", iss_if.iss_valid_o, iss_if.iss_dst_id_o, select); else pass_cnt++;
        rst_n = 1'b1;
        ev = '0; er = '0;
    endtask

    task automatic test_random();
        for (int c = 0; c < 60; c++) begin
            ev = 8'($urandom);
            er = 8'($urandom);
            iss_if.fu_ready_i = ($urandom_range(3) != 0);
            alloc_valid = $urandom_range(1);
            alloc_idx = 3'($urandom_range(7));
            flush = ($urandom_range(9) == 0);
            #2; predict();
            total_cnt++; if (select !== exp_sel || iss_if.wkup_reg_id_o !== exp_wid || iss_if.wkup_valid_o !== (|exp_sel))
                $display("FAIL rand_select c%0d got %h/%h exp %h/%h", c, select, iss_if.wkup_reg_id_o, exp_sel, exp_wid); else pass_cnt++;
            advance();
            total_cnt++; if (iss_if.iss_valid_o !== m_iss_valid || iss_if.iss_dst_id_o !== exp_pay.dst || iss_if.iss_data_o !== exp_pay.data)
                $display("FAIL rand_issue c%0d got v=%b dst=%h exp v=%b dst=%h", c, iss_if.iss_valid_o, iss_if.iss_dst_id_o, m_iss_valid, exp_pay.dst); else pass_cnt++;
        end
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; alloc_valid = 1'b0; alloc_idx = '0;
        ev = '0; er = '0; iss_if.fu_ready_i = 1'b1;
        m_iss_valid = 0; stamp_ctr = 0;
        foreach (m_stamp[i]) m_stamp[i] = -1;
        for (int i = 0; i < D; i++) begin
            for (int r = 0; r < R; r++) edata[i][r] = 32'hA000_0000 | (i << 8) | r;
            edi[i] = '{opcode: 5'(i + 1), fu_sel: 3'(i)};
            edst[i] = 6'(i + 10);
        end
        @(posedge clk); #1;
        test_reset();
        test_age_order();
        test_fu_stall();
        test_wakeup();
        test_flush();
        test_alloc_same();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule

// File: doc/iq_issue_select.md
IQ_ISSUE_SELECT -- requirements
Module: iq_issue_select

Interface
REQ-001 Parameter IQ_DEPTH, default 8, number of issue-queue entries arbitrated.
REQ-002 Parameter REG_COUNT, default 2, source operands per instruction.
REQ-003 The clock is clk: one clock; reset is synchronous and active-low via rst_n; all state updates on posedge clk.
REQ-004 clk  input  1  system clock.
REQ-005 rst_n  input  1  synchronous active-low reset.
REQ-006 flush  input  1  pipeline flush; kills all arbitration state and the issue register.
REQ-007 alloc_valid_i  input  1  a new instruction is written into an entry this cycle.
REQ-008 alloc_idx_i  input  $clog2(IQ_DEPTH)  index of the entry being allocated.
REQ-009 entry_valid_i  input  IQ_DEPTH  entry holds a live instruction.
REQ-010 entry_ready_i  input  IQ_DEPTH  entry operands ready (entry ready_o).
REQ-011 entry_data_i  input  IQ_DEPTH x REG_COUNT x word_t  entry operand values (entry data_o).
REQ-012 entry_di_i  input  IQ_DEPTH x decode_info_t  entry control info (entry di_o).
REQ-013 entry_dst_id_i  input  IQ_DEPTH x rob_id_t  destination rob id of each entry.
REQ-014 select_o  output  IQ_DEPTH  one-hot issue grant, drives entry select_i.
REQ-015 wkup_valid_o  output  1  back-to-back wakeup broadcast valid.
REQ-016 wkup_reg_id_o  output  rob_id_t  rob id being woken up.
REQ-017 iss_valid_o  output  1  issue register holds an instruction for the FU.
REQ-018 fu_ready_i  input  1  FU accepts the issue register this cycle.
REQ-019 iss_data_o  output  REG_COUNT x word_t  issued operands.
REQ-020 iss_di_o  output  decode_info_t  issued control info.
REQ-021 iss_dst_id_o  output  rob_id_t  issued destination rob id.

Function
REQ-022 Age matrix age_q[i][j]=1 means entry i older than entry j; diagonal ignored.
REQ-023 On alloc_valid_i with index k: row k cleared to 0, column k set to 1 (all others older than k), next cycle.
REQ-024 Request req[i] = entry_valid_i[i] & entry_ready_i[i].
REQ-025 Grant: req[i] & no j!=i with req[j] & age_q[j][i]; at most one grant bit set.
REQ-026 accept = ~iss_valid_q | fu_ready_i; select_o = grant & accept & ~flush, combinational same cycle.
REQ-027 No request or accept=0 -> select_o all zero, issue register unchanged except FU drain.
REQ-028 On select of entry k: next cycle iss_valid_o=1 with entry_data_i[k], entry_di_i[k], entry_dst_id_i[k] captured.
REQ-029 No select and fu_ready_i=1 -> iss_valid_o cleared next cycle; no select and fu_ready_i=0 -> hold.
REQ-030 Select and fu_ready_i same cycle -> new instruction replaces old (full throughput, 1 issue/cycle).
REQ-031 wkup_valid_o = |select_o; wkup_reg_id_o = entry_dst_id_i of granted entry, else 0; same cycle as select.
REQ-032 Alloc and select of same index same cycle: select uses current entry contents; age update for alloc applies.
REQ-033 flush: select_o=0, wkup_valid_o=0, iss_valid_o cleared next cycle, age_q cleared.
REQ-034 Issue payload outputs hold last value while iss_valid_o=0; consumers qualify with iss_valid_o.

Reset
REQ-035 rst_n=0 at posedge clk: age_q, iss_valid_o, iss_data_o, iss_di_o, iss_dst_id_o all 0.
REQ-036 During reset select_o and wkup_valid_o are 0; reset mid-issue drops the in-flight instruction.

Structure
REQ-037 word_t, rob_id_t, decode_info_t come from the shared a_defines package; no new typedefs local to this block.
REQ-038 Age matrix and grant logic are one sub-module iq_age_matrix (alloc in, req in, grant out).
REQ-039 Issue register and wakeup generation live in iq_issue_select top.

Verification
REQ-040 Alloc idx 3 then idx 1, both ready -> select_o=8'h08, next cycle iss_dst_id_o = entry 3 id, then 8'h02.
REQ-041 iss_valid_o=1, fu_ready_i=0, entry 0 ready -> select_o=0, wkup_valid_o=0, payload held.
REQ-042 Entry 5 ready, dst id 17, fu_ready_i=1 every cycle -> wkup_valid_o=1, wkup_reg_id_o=17, iss_valid_o=1 next cycle.
REQ-043 flush with iss_valid_o=1 and entry 2 ready -> select_o=0, iss_valid_o=0 next cycle, age_q zero.
REQ-044 Alloc idx 4 while entry 4 selected same cycle -> select_o=8'h10, payload = old entry 4, entry 4 youngest after.
REQ-045 rst_n=0 asserted during back-to-back issue -> all outputs 0 next cycle, no stray select.
